// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a four-state
// qualification FSM that emits a clean level, edge strobes and a press counter.
module btn_debounce #(
   parameter int DB_CYCLES = 8,
   parameter int CNT_W     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   output logic       btn_level,
   output logic       rise_pulse,
   output logic       fall_pulse,
   output logic       bouncing,
   output logic [7:0] press_cnt
);

   localparam int SYNC_STAGES = 2;

   localparam logic [1:0] S_LOW   = 2'd0;
   localparam logic [1:0] S_CHK_H = 2'd1;
   localparam logic [1:0] S_HIGH  = 2'd2;
   localparam logic [1:0] S_CHK_L = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // sync_reg[0] is the metastability-catching flop; the last stage feeds the FSM
   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   sync2;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         always_ff @(posedge clk) begin
            if (rst) begin
               sync_reg[gi] <= 1'b0;
            end else if (gi == 0) begin
               sync_reg[gi] <= btn_in;
            end else begin
               sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
            end
         end
      end
   endgenerate

   assign sync2 = sync_reg[SYNC_STAGES-1];

   logic [1:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             level_reg, level_next;
   logic             rise_reg, rise_next;
   logic             fall_reg, fall_next;
   logic [7:0]       press_reg, press_next;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      level_next = level_reg;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      press_next = press_reg;
      case (state_reg)
         S_LOW: begin
            if (sync2) begin
               state_next = S_CHK_H;
               cnt_next   = CNT_ONE;
            end
         end
         S_CHK_H: begin
            if (!sync2) begin
               state_next = S_LOW;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = S_HIGH;
               cnt_next   = '0;
               level_next = 1'b1;
               rise_next  = 1'b1;
               press_next = press_reg + 8'd1;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         S_HIGH: begin
            if (!sync2) begin
               state_next = S_CHK_L;
               cnt_next   = CNT_ONE;
            end
         end
         S_CHK_L: begin
            if (sync2) begin
               state_next = S_HIGH;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = S_LOW;
               cnt_next   = '0;
               level_next = 1'b0;
               fall_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         default: begin
            state_next = S_LOW;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_LOW;
         cnt_reg   <= '0;
         level_reg <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
         press_reg <= 8'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         level_reg <= level_next;
         rise_reg  <= rise_next;
         fall_reg  <= fall_next;
         press_reg <= press_next;
      end
   end

   // Decoded from the state register only, so no input reaches an output combinationally
   assign bouncing   = (state_reg == S_CHK_H) || (state_reg == S_CHK_L);
   assign btn_level  = level_reg;
   assign rise_pulse = rise_reg;
   assign fall_pulse = fall_reg;
   assign press_cnt  = press_reg;

endmodule
